// File: rtl/hwf_pkg.sv
// Shared types and width helpers for the hwf_kernel sequencer.
// Sequencer FSM states, default geometry and address/result width derivation.
package hwf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } hwf_state_e;

    localparam int DEF_XLEN_PIXEL    = 8;
    localparam int DEF_NUM_OF_PIXELS = 4;
    localparam int DEF_NUM_OF_SV     = 87;

    // Address width for a memory of n words; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Kernel result width: product of two pixels.
    function automatic int kres_w(input int xlen);
        return 2 * xlen;
    endfunction

    localparam int DEF_TEST_AW  = addr_w(DEF_NUM_OF_PIXELS);
    localparam int DEF_SV_AW    = addr_w(DEF_NUM_OF_SV * DEF_NUM_OF_PIXELS);
    localparam int DEF_ALPHA_AW = addr_w(DEF_NUM_OF_SV);
    localparam int DEF_KRES_W   = kres_w(DEF_XLEN_PIXEL);

endpackage

// File: rtl/hwf_addr_gen.sv
// Pixel/SV read-address counters for the hwf sequencer.
// Counters advance on adv, hold otherwise, and return to zero after the last beat.
module hwf_addr_gen
    import hwf_pkg::*;
#(
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
    parameter int NUM_OF_SV     = DEF_NUM_OF_SV
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       clr,
    input  logic                                       adv,
    output logic [addr_w(NUM_OF_PIXELS)-1:0]           test_addr,
    output logic [addr_w(NUM_OF_SV*NUM_OF_PIXELS)-1:0] sv_addr,
    output logic [addr_w(NUM_OF_SV)-1:0]               alpha_addr,
    output logic                                       pix_last,
    output logic                                       last_beat
);
    localparam int PIX_AW = addr_w(NUM_OF_PIXELS);
    localparam int SVP_AW = addr_w(NUM_OF_SV * NUM_OF_PIXELS);
    localparam int SV_AW  = addr_w(NUM_OF_SV);
    localparam logic [PIX_AW-1:0] P_LAST = PIX_AW'(NUM_OF_PIXELS - 1);
    localparam logic [SV_AW-1:0]  S_LAST = SV_AW'(NUM_OF_SV - 1);

    logic [PIX_AW-1:0] p_r, p_s;
    logic [SV_AW-1:0]  s_r, s_s;
    logic [SVP_AW-1:0] a_r, a_s;

    assign test_addr  = p_r;
    assign sv_addr    = a_r;
    assign alpha_addr = s_r;
    assign pix_last   = (p_r == P_LAST);
    assign last_beat  = pix_last && (s_r == S_LAST);

    // Next counter values; sv_addr tracks s*NUM_OF_PIXELS+p as a linear count.
    always_comb begin
        p_s = p_r;
        s_s = s_r;
        a_s = a_r;
        if (clr || (adv && last_beat)) begin
            p_s = {PIX_AW{1'b0}};
            s_s = {SV_AW{1'b0}};
            a_s = {SVP_AW{1'b0}};
        end else if (adv) begin
            a_s = a_r + SVP_AW'(1);
            if (pix_last) begin
                p_s = {PIX_AW{1'b0}};
                s_s = s_r + SV_AW'(1);
            end else begin
                p_s = p_r + PIX_AW'(1);
                s_s = s_r;
            end
        end else begin
            p_s = p_r;
            s_s = s_r;
            a_s = a_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_r <= {PIX_AW{1'b0}};
            s_r <= {SV_AW{1'b0}};
            a_r <= {SVP_AW{1'b0}};
        end else begin
            p_r <= p_s;
            s_r <= s_s;
            a_r <= a_s;
        end
    end

endmodule

// File: rtl/hwf_sv_scheduler.sv
// Support-vector sequencer for hwf_kernel: addresses, kernel stall, decision accumulation.
// Optional feature macro HWF_SCHED_BIAS_EN adds a bias input folded into the decision.
module hwf_sv_scheduler
    import hwf_pkg::*;
#(
    parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
    parameter int NUM_OF_SV     = DEF_NUM_OF_SV,
    parameter int KERNEL_LAT    = 2,
    parameter int ACC_W         = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       mem_wait,
    output logic [addr_w(NUM_OF_PIXELS)-1:0]           test_addr,
    output logic [addr_w(NUM_OF_SV*NUM_OF_PIXELS)-1:0] sv_addr,
    output logic [addr_w(NUM_OF_SV)-1:0]               alpha_addr,
    output logic                                       stall_MEM,
    output logic                                       sv_last,
    input  logic signed [kres_w(XLEN_PIXEL)-1:0]       hwf_out,
`ifdef HWF_SCHED_BIAS_EN
    input  logic signed [ACC_W-1:0]                    bias,
`endif
    output logic                                       busy,
    output logic                                       done,
    output logic signed [ACC_W-1:0]                    decision,
    output logic                                       class_out
);
    hwf_state_e state_r, state_s;

    logic                    start_ok_s, beat_s, pix_last_s, last_beat_s, tap_s;
    logic                    stall_r, sv_last_r, busy_r, done_r, class_r;
    logic [KERNEL_LAT-1:0]   vld_r, vld_s;
    logic signed [ACC_W-1:0] acc_r, acc_s, dec_r, dec_s;

    assign start_ok_s = (state_r == ST_IDLE) && start;
    assign beat_s     = (state_r == ST_STREAM) && !mem_wait;

    hwf_addr_gen #(
        .NUM_OF_PIXELS (NUM_OF_PIXELS),
        .NUM_OF_SV     (NUM_OF_SV)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok_s),
        .adv        (beat_s),
        .test_addr  (test_addr),
        .sv_addr    (sv_addr),
        .alpha_addr (alpha_addr),
        .pix_last   (pix_last_s),
        .last_beat  (last_beat_s)
    );

    // Next-state logic; DRAIN ends once the valid pipe will hold no pending SV.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_STREAM;
                else       state_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (beat_s && last_beat_s) state_s = ST_DRAIN;
                else                       state_s = ST_STREAM;
            end
            ST_DRAIN: begin
                if (vld_s == {KERNEL_LAT{1'b0}}) state_s = ST_DONE;
                else                             state_s = ST_DRAIN;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Valid pipe and accumulator; both freeze while the kernel is stalled.
    always_comb begin
        vld_s = vld_r;
        acc_s = acc_r;
        tap_s = vld_r[KERNEL_LAT-1] && !stall_r;
        if (start_ok_s) begin
            vld_s = {KERNEL_LAT{1'b0}};
            acc_s = {ACC_W{1'b0}};
        end else begin
            if (!stall_r) vld_s = KERNEL_LAT'({vld_r, sv_last_r});
            else          vld_s = vld_r;
            if (tap_s) acc_s = acc_r + ACC_W'(hwf_out);
            else       acc_s = acc_r;
        end
`ifdef HWF_SCHED_BIAS_EN
        dec_s = acc_s + bias;
`else
        dec_s = acc_s;
`endif
    end

    // State and registered outputs; decision captured on DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            vld_r     <= {KERNEL_LAT{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            dec_r     <= {ACC_W{1'b0}};
            class_r   <= 1'b0;
            stall_r   <= 1'b1;
            sv_last_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            vld_r     <= vld_s;
            acc_r     <= acc_s;
            stall_r   <= !(beat_s || (state_s == ST_DRAIN));
            sv_last_r <= beat_s && pix_last_s;
            busy_r    <= (state_s == ST_STREAM) || (state_s == ST_DRAIN);
            done_r    <= (state_s == ST_DONE);
            if (state_s == ST_DONE) begin
                dec_r   <= dec_s;
                class_r <= !dec_s[ACC_W-1];
            end
        end
    end

    assign stall_MEM = stall_r;
    assign sv_last   = sv_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign decision  = dec_r;
    assign class_out = class_r;

endmodule

// File: tb/tb_hwf_sv_scheduler.sv
// Self-checking bench for hwf_sv_scheduler (4 pixels, 3 SVs, kernel latency 2).
// Builds with or without HWF_SCHED_BIAS_EN; a behavioural ROM+kernel feeds hwf_out.
module tb_hwf_sv_scheduler;
    localparam int NP  = 4;
    localparam int NSV = 3;
    localparam int LAT = 2;
    localparam int XL  = 8;
    localparam int AW  = 32;
    localparam int N   = NP * NSV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic mem_wait = 1'b0;
    logic [1:0] test_addr;
    logic [3:0] sv_addr;
    logic [1:0] alpha_addr;
    logic stall_MEM, sv_last, busy, done, class_out;
    logic signed [15:0] hwf_out;
    logic signed [31:0] decision;
    logic signed [31:0] bias_v = 32'sd0;
    logic signed [15:0] kval [NSV];

    int rom_r;
    int kp [LAT];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    hwf_sv_scheduler #(
        .XLEN_PIXEL(XL), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV), .KERNEL_LAT(LAT), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mem_wait(mem_wait),
        .test_addr(test_addr), .sv_addr(sv_addr), .alpha_addr(alpha_addr),
        .stall_MEM(stall_MEM), .sv_last(sv_last), .hwf_out(hwf_out),
`ifdef HWF_SCHED_BIAS_EN
        .bias(bias_v),
`endif
        .busy(busy), .done(done), .decision(decision), .class_out(class_out)
    );

    // SV memory (1-cycle read) feeding a kernel pipe that holds while stalled.
    always @(posedge clk) begin
        rom_r <= int'(sv_addr) / NP;
        if (!stall_MEM) begin
            kp[0] <= rom_r;
            for (int i = 1; i < LAT; i++) kp[i] <= kp[i-1];
        end
    end
    assign hwf_out = kval[kp[LAT-1] % NSV];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string where);
        check_val({where, "_test_addr"}, test_addr, 0);
        check_val({where, "_sv_addr"}, sv_addr, 0);
        check_val({where, "_alpha_addr"}, alpha_addr, 0);
        check_val({where, "_stall"}, stall_MEM, 1);
        check_val({where, "_sv_last"}, sv_last, 0);
        check_val({where, "_busy"}, busy, 0);
        check_val({where, "_done"}, done, 0);
        check_val({where, "_decision"}, decision, 0);
        check_val({where, "_class"}, class_out, 0);
    endtask

    // One classification; mode 0 = no wait, 1 = wait in cycles 3..5, 2 = random wait.
    task automatic run(input int mode, input int retrig, input int abort);
        int issued, last_cyc, nwait, done_cyc, c;
        bit prev_beat, prev_plast, beat, draining;
        logic signed [31:0] exp_dec;
        exp_dec = bias_v;
        for (int i = 0; i < NSV; i++) exp_dec = exp_dec + kval[i];
        issued = 0; last_cyc = -1; nwait = 0; done_cyc = -1;
        prev_beat = 1'b0; prev_plast = 1'b0;
        cyc = 0;
        start = 1'b1;
        mem_wait = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        start = 1'b0;
        for (c = 1; c < 200; c++) begin
            if (mode == 1)      mem_wait = (c >= 3 && c <= 5);
            else if (mode == 2) mem_wait = 1'($urandom_range(0, 1));
            else                mem_wait = 1'b0;
            start = (c == retrig);
            if (c == abort) begin
                rst = 1'b0;
                #1;
                check_reset_vals("abort");
                #1;
                rst = 1'b1;
                start = 1'b0;
                mem_wait = 1'b0;
                return;
            end
            if (issued < N) begin
                check_val("sv_addr", sv_addr, issued);
                check_val("test_addr", test_addr, issued % NP);
                check_val("alpha_addr", alpha_addr, issued / NP);
            end
            draining = (last_cyc >= 0) && (c <= last_cyc + 1 + LAT);
            check_val("stall_MEM", stall_MEM, !(prev_beat || draining));
            check_val("sv_last", sv_last, prev_beat && prev_plast);
            check_val("busy", busy, (last_cyc < 0) || draining);
            check_val("done", done, (last_cyc >= 0) && (c == last_cyc + 2 + LAT));
            if (done && done_cyc < 0) done_cyc = c;
            if (last_cyc >= 0 && c == last_cyc + 2 + LAT) begin
                check_val("decision", decision, exp_dec);
                check_val("class_out", class_out, exp_dec >= 0);
            end
            beat = (issued < N) && !mem_wait;
            if (!beat && issued < N) nwait++;
            prev_plast = beat && (issued % NP == NP - 1);
            prev_beat = beat;
            if (beat) begin
                issued++;
                if (issued == N) last_cyc = c;
            end
            step();
            if (last_cyc >= 0 && c == last_cyc + 2 + LAT) break;
        end
        start = 1'b0;
        mem_wait = 1'b0;
        check_val("done_cycle", done_cyc, N + 2 + LAT + nwait);
        check_val("idle_busy", busy, 0);
        check_val("idle_done", done, 0);
        check_val("idle_stall", stall_MEM, 1);
        check_val("decision_hold", decision, exp_dec);
    endtask

    initial begin
        kval[0] = 16'sd100;
        kval[1] = -16'sd30;
        kval[2] = -16'sd50;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;
        step();
`ifdef HWF_SCHED_BIAS_EN
        bias_v = -32'sd25;
`endif
        run(0, -1, -1);
        run(1, -1, -1);
        run(0, 7, -1);
        run(0, -1, 6);
        run(0, -1, -1);
        for (int i = 0; i < NSV; i++) kval[i] = 16'sh8000;
`ifdef HWF_SCHED_BIAS_EN
        bias_v = 32'sd0;
`endif
        run(0, -1, -1);
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NSV; i++) kval[i] = 16'($urandom);
`ifdef HWF_SCHED_BIAS_EN
            bias_v = 32'($urandom);
`endif
            run(2, (r % 3 == 0) ? int'($urandom_range(2, 10)) : -1, -1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
